// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Shares one WIDTH-bit register bank between two requesters. Each requester
//   issues a LOAD / CLEAR / SET / TOGGLE command. The two requesters are
//   arbitrated round-robin. Every applied command locks the bank for
//   HOLD_CYCLES cycles, and no other command is accepted during the lock.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   req0/req1    in   command request, held until the matching gnt
//   cmd0/cmd1    in   2-bit command: 00 LOAD, 01 CLEAR, 10 SET, 11 TOGGLE
//   data0/data1  in   WIDTH-bit load data (used only by LOAD)
//   gnt0/gnt1    out  one-cycle pulse: that requester's command was applied
//   busy         out  bank locked (HOLD state)
//   last_src     out  index of the most recently granted requester
//   q            out  register bank contents
module dff_bank_arbiter #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       cmd0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             last_src,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
    // The counter counts down to zero, and the cycle at zero is the last
    // locked cycle. So it starts one below HOLD_CYCLES.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_SET   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic             last_src_q, last_src_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] bank_q, bank_d;

    logic             sel_valid;
    logic             sel_idx;
    logic [1:0]       sel_cmd;
    logic [WIDTH-1:0] sel_data;

    function automatic logic [WIDTH-1:0] apply_cmd(
        input logic [1:0]       cmd,
        input logic [WIDTH-1:0] data,
        input logic [WIDTH-1:0] cur
    );
        case (cmd)
            CMD_LOAD:  apply_cmd = data;
            CMD_CLEAR: apply_cmd = '0;
            CMD_SET:   apply_cmd = '1;
            default:   apply_cmd = ~cur;
        endcase
    endfunction

    // Requester selection. Requests are only considered in IDLE. The round-robin
    // pointer matters only when both requesters ask in the same cycle.
    always_comb begin
        sel_valid = (state_q == ST_IDLE) && (req0 || req1);
        if (req0 && req1) begin
            sel_idx = rr_q;
        end else begin
            sel_idx = req1;
        end
        sel_cmd  = sel_idx ? cmd1  : cmd0;
        sel_data = sel_idx ? data1 : data0;
    end

    // State register (all control and bank flops share the asynchronous reset)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            last_src_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            bank_q     <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            last_src_q <= last_src_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            bank_q     <= bank_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Output logic. The grant pulses and the bank update are registered at the
    // selecting edge. The grant is therefore visible only in the first HOLD cycle.
    always_comb begin
        bank_d     = bank_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        last_src_d = last_src_q;
        rr_d       = rr_q;
        if (sel_valid) begin
            bank_d     = apply_cmd(sel_cmd, sel_data, bank_q);
            gnt0_d     = ~sel_idx;
            gnt1_d     = sel_idx;
            last_src_d = sel_idx;
            rr_d       = ~sel_idx;
        end
        busy     = (state_q == ST_HOLD);
        gnt0     = gnt0_q;
        gnt1     = gnt1_q;
        last_src = last_src_q;
        q        = bank_q;
    end

endmodule
